// File: rtl/ldpc_cn_minsum_simd.sv
// ldpc_cn_minsum_simd: SIMD min-sum LDPC check-node unit; accumulates deg packed beats, then streams deg extrinsic messages.
module ldpc_cn_minsum_simd #(
    parameter int XLEN    = 64,
    parameter int Q       = 8,
    parameter int SIMD    = XLEN / Q,
    parameter int MAX_DEG = 16,
    parameter int SAT_MAX = 63,
    localparam int DW     = $clog2(MAX_DEG + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [DW-1:0]   deg_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_data_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);
    typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

    state_t          state_q;
    logic [DW-1:0]   deg_q, cnt_q, j_n;
    logic [Q-1:0]    min1_q [SIMD];
    logic [Q-1:0]    min2_q [SIMD];
    logic [DW-1:0]   idx_q  [SIMD];
    logic [SIMD-1:0] sgn_q;
    logic [XLEN-1:0] buf_q  [MAX_DEG];
    logic [XLEN-1:0] out_q, out_d;
    logic            done_q, err_q;
    logic [Q-1:0]    min1_d [SIMD];
    logic [Q-1:0]    min2_d [SIMD];
    logic [DW-1:0]   idx_d  [SIMD];
    logic [SIMD-1:0] sgn_d;
    logic [Q-1:0]    m      [SIMD];
    logic [Q-1:0]    mag    [SIMD];
    logic            acc_hs, last;

    // |v| at Q+1 bits so the most negative code saturates instead of wrapping
    function automatic logic [Q-1:0] mag_f(input logic [Q-1:0] v);
        logic [Q:0] a;
        a = v[Q-1] ? -{v[Q-1], v} : {v[Q-1], v};
        return (a > (Q+1)'(SAT_MAX)) ? Q'(SAT_MAX) : a[Q-1:0];
    endfunction

    assign acc_hs      = state_q == ACC && in_valid_i;
    assign last        = cnt_q == deg_q - 1'b1;
    assign j_n         = (acc_hs || last) ? '0 : cnt_q + 1'b1;
    assign in_ready_o  = state_q == ACC;
    assign out_valid_o = state_q == EMIT;
    assign busy_o      = state_q != IDLE;
    assign out_data_o  = out_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    // out_d is the message for the beat that will be presented next, built from next-state minima
    always_comb begin
        for (int l = 0; l < SIMD; l++) begin
            m[l]      = mag_f(in_data_i[l*Q +: Q]);
            min1_d[l] = (acc_hs && m[l] < min1_q[l]) ? m[l] : min1_q[l];
            min2_d[l] = !acc_hs ? min2_q[l] : m[l] < min1_q[l] ? min1_q[l] : m[l] < min2_q[l] ? m[l] : min2_q[l];
            idx_d[l]  = (acc_hs && m[l] < min1_q[l]) ? cnt_q : idx_q[l];
            sgn_d[l]  = sgn_q[l] ^ (acc_hs & in_data_i[l*Q+Q-1]);
            mag[l]    = (j_n == idx_d[l]) ? min2_d[l] : min1_d[l];
            out_d[l*Q +: Q] = (sgn_d[l] ^ buf_q[j_n][l*Q+Q-1]) ? -mag[l] : mag[l];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            deg_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int l = 0; l < SIMD; l++) begin
                min1_q[l] <= '0;
                min2_q[l] <= '0;
                idx_q[l]  <= '0;
            end
            for (int k = 0; k < MAX_DEG; k++) buf_q[k] <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    if (deg_i >= DW'(2) && deg_i <= DW'(MAX_DEG)) begin
                        state_q <= ACC;
                        deg_q   <= deg_i;
                        cnt_q   <= '0;
                        sgn_q   <= '0;
                        for (int l = 0; l < SIMD; l++) begin
                            min1_q[l] <= Q'(SAT_MAX);
                            min2_q[l] <= Q'(SAT_MAX);
                            idx_q[l]  <= '0;
                        end
                    end else err_q <= 1'b1;
                end
                ACC: if (in_valid_i) begin
                    buf_q[cnt_q] <= in_data_i;
                    sgn_q        <= sgn_d;
                    min1_q       <= min1_d;
                    min2_q       <= min2_d;
                    idx_q        <= idx_d;
                    cnt_q        <= last ? '0 : cnt_q + 1'b1;
                    if (last) begin
                        state_q <= EMIT;
                        out_q   <= out_d;
                    end
                end
                EMIT: if (out_ready_i) begin
                    cnt_q   <= last ? '0 : cnt_q + 1'b1;
                    out_q   <= last ? '0 : out_d;
                    done_q  <= last;
                    state_q <= last ? IDLE : EMIT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_cn_minsum_simd.sv
// tb_ldpc_cn_minsum_simd: randomized and directed check of the min-sum check node against a leave-one-out reference.
module tb_ldpc_cn_minsum_simd;
    localparam int XLEN = 64, Q = 8, SIMD = 8, MAX_DEG = 16, SAT_MAX = 63, DW = 5;

    logic            clk_i = 0, rst_ni = 0, flush_i = 0, start_i = 0;
    logic [DW-1:0]   deg_i = '0;
    logic            in_valid_i = 0, in_ready_o, out_valid_o, out_ready_i = 0;
    logic [XLEN-1:0] in_data_i = '0, out_data_o;
    logic            busy_o, done_o, err_o;
    logic [XLEN-1:0] beats [MAX_DEG];
    int              total = 0, bad = 0;

    ldpc_cn_minsum_simd #(.XLEN(XLEN), .Q(Q), .SIMD(SIMD), .MAX_DEG(MAX_DEG), .SAT_MAX(SAT_MAX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .start_i(start_i), .deg_i(deg_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // extrinsic message: min of saturated magnitudes and xor of signs over every other beat
    function automatic logic [XLEN-1:0] model(input int deg, input int j);
        logic [XLEN-1:0] r = '0;
        for (int l = 0; l < SIMD; l++) begin
            int mn = 1000, o, v, a;
            bit s = 0;
            for (int k = 0; k < deg; k++) if (k != j) begin
                v = $signed(beats[k][l*Q +: Q]);
                a = v < 0 ? -v : v;
                if (a > SAT_MAX) a = SAT_MAX;
                if (a < mn) mn = a;
                s ^= beats[k][l*Q+Q-1];
            end
            o = s ? -mn : mn;
            r[l*Q +: Q] = o[Q-1:0];
        end
        return r;
    endfunction

    task automatic feed(input int deg);
        int k = 0, cyc = 0;
        bit hs;
        start_i = 1; deg_i = DW'(deg);
        @(posedge clk_i); #1; start_i = 0;
        while (k < deg && cyc < 1000) begin
            in_valid_i = ($urandom_range(3) != 0);
            in_data_i  = beats[k];
            start_i    = $urandom_range(1);
            deg_i      = $urandom_range(1) ? DW'(1) : DW'(3);
            @(negedge clk_i);
            chk("acc_in_ready", in_ready_o, 1);
            chk("acc_err", err_o, 0);
            hs = in_valid_i && in_ready_o;
            @(posedge clk_i); #1;
            if (hs) k++;
            cyc++;
        end
        in_valid_i = 0;
        if (k < deg) chk("acc_timeout", k, deg);
    endtask

    task automatic run_node(input int deg, input int rmode);
        int j = 0, cyc = 0;
        bit hs;
        feed(deg);
        while (j < deg && cyc < 1000) begin
            out_ready_i = rmode == 1 ? 1'b1 : rmode == 2 ? (cyc >= 5) : 1'($urandom_range(1));
            start_i     = $urandom_range(1);
            @(negedge clk_i);
            chk("out_valid", out_valid_o, 1);
            chk($sformatf("out_data_d%0d_j%0d", deg, j), out_data_o, model(deg, j));
            chk("emit_in_ready", in_ready_o, 0);
            chk("emit_done", done_o, 0);
            hs = out_ready_i;
            @(posedge clk_i); #1;
            if (hs) j++;
            cyc++;
        end
        start_i = 0; out_ready_i = 0;
        if (j < deg) chk("emit_timeout", j, deg);
        @(negedge clk_i);
        chk("done_pulse", done_o, 1);
        chk("busy_after", busy_o, 0);
        chk("valid_after", out_valid_o, 0);
        @(negedge clk_i);
        chk("done_clear", done_o, 0);
        #1;
    endtask

    task automatic bad_start(input int d);
        start_i = 1; deg_i = DW'(d);
        @(posedge clk_i); #1; start_i = 0;
        @(negedge clk_i);
        chk($sformatf("err_deg%0d", d), err_o, 1);
        chk("err_busy", busy_o, 0);
        chk("err_in_ready", in_ready_o, 0);
        @(negedge clk_i);
        chk("err_clear", err_o, 0);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        @(posedge clk_i); #1; rst_ni = 1;
        @(posedge clk_i); #1;

        beats[0] = 64'h05; beats[1] = 64'hFE; beats[2] = 64'h07;
        run_node(3, 1);
        beats[0] = 64'h80; beats[1] = 64'h7F;
        run_node(2, 0);
        for (int k = 0; k < 4; k++) beats[k] = {8{8'h03}};
        run_node(4, 0);
        beats[0] = {$urandom, $urandom}; beats[1] = {$urandom, $urandom};
        run_node(2, 2);

        bad_start(1);
        bad_start(MAX_DEG + 1);
        bad_start(0);

        for (int k = 0; k < 4; k++) beats[k] = {$urandom, $urandom};
        start_i = 1; deg_i = 4;
        @(posedge clk_i); #1; start_i = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid_i = 1; in_data_i = beats[k];
            @(posedge clk_i); #1;
        end
        in_valid_i = 0; flush_i = 1;
        @(posedge clk_i); #1; flush_i = 0;
        @(negedge clk_i);
        chk("flush_busy", busy_o, 0);
        chk("flush_done", done_o, 0);
        chk("flush_in_ready", in_ready_o, 0);
        #1;
        beats[0] = {$urandom, $urandom}; beats[1] = {$urandom, $urandom};
        run_node(2, 0);

        beats[0] = {$urandom, $urandom}; beats[1] = {$urandom, $urandom};
        feed(2);
        @(negedge clk_i);
        chk("pre_rst_valid", out_valid_o, 1);
        #2 rst_ni = 0;
        #1;
        chk("arst_out_valid", out_valid_o, 0);
        chk("arst_out_data", out_data_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_in_ready", in_ready_o, 0);
        chk("arst_done", done_o, 0);
        @(posedge clk_i); #1; rst_ni = 1;
        @(posedge clk_i); #1;

        for (int k = 0; k < MAX_DEG; k++) beats[k] = {$urandom, $urandom};
        run_node(MAX_DEG, 0);
        for (int n = 0; n < 25; n++) begin
            int d = $urandom_range(MAX_DEG, 2);
            for (int k = 0; k < d; k++) begin
                beats[k] = {$urandom, $urandom};
                for (int l = 0; l < SIMD; l++)
                    if ($urandom_range(7) == 0) beats[k][l*Q +: Q] = $urandom_range(1) ? 8'h80 : 8'h7F;
            end
            run_node(d, $urandom_range(2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ldpc_cn_minsum_simd.md
Name: ldpc_cn_minsum_simd

Overview:
- Parametrised SIMD check-node processor for the LDPC decoder.
- Generalises the single-lane 8-bit min/saturating-add/sub ALU ops to Q-bit lanes packed in XLEN, processed across a multi-beat check node.
- Accumulates a check node of degree deg (one packed vector per beat) and tracks per lane: min1, min2, min1 index and sign parity.
- Then streams deg extrinsic min-sum messages back out. Sits beside the ALU as a multi-cycle functional unit.

Parameters:
- XLEN, 64, datapath width
- Q, 8, bits per lane (signed two's complement)
- SIMD, XLEN/Q, lane count; XLEN must equal SIMD*Q
- MAX_DEG, 16, maximum check-node degree (>=2)
- SAT_MAX, 63, magnitude saturation bound; must be <= 2^(Q-1)-1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  synchronous abort to IDLE
- start_i  in  1  begin a new check node (sampled in IDLE only)
- deg_i  in  $clog2(MAX_DEG+1)  degree of the check node, sampled with start_i
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
- in_data_i  in  XLEN  packed SIMD variable-to-check messages
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  output beat consumed when out_valid_o & out_ready_i
- out_data_o  out  XLEN  packed SIMD check-to-variable messages
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse on the final output handshake
- err_o  out  1  one-cycle pulse when start_i carries illegal deg_i

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, all counters/min/sign/buffer registers 0; in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0, err_o=0.
- FSM IDLE -> ACC -> EMIT -> IDLE.
- IDLE, start_i=1:
  - deg_i in [2, MAX_DEG]: latch deg; per lane init min1=SAT_MAX, min2=SAT_MAX, idx=0, sgn=0; beat count=0; go to ACC next cycle.
  - Otherwise: err_o=1 next cycle, stay in IDLE.
  - start_i is ignored outside IDLE.
- ACC: in_ready_o=1 (registered state decode; no combinational dependence on in_valid_i). On each handshake with beat k, per lane value v:
  - s = v[Q-1].
  - m = min(|v|, SAT_MAX) computed at Q+1 bits, so -2^(Q-1) saturates to SAT_MAX.
  - Store v in buffer[k].
  - sgn ^= s.
  - If m < min1: min2=min1, min1=m, idx=k.
  - Else if m < min2: min2=m.
  - Ties: equal to min1 updates only min2. min1 index stays the first occurrence.
  - After the handshake with k==deg-1, go to EMIT next cycle.
- EMIT: in_ready_o=0, out_valid_o=1. Beat j, per lane:
  - mag = (j==idx) ? min2 : min1.
  - sign = sgn ^ buffer[j][Q-1].
  - out = sign ? -mag : mag (Q-bit; fits because mag <= SAT_MAX).
  - out_data_o is driven from registers only.
  - Holds stable while out_ready_i=0.
  - On handshake, j advances. On the handshake with j==deg-1: done_o pulses, state goes to IDLE.
- Latency: first out_valid_o is asserted the cycle after the last input handshake. Throughput is 1 beat/cycle each direction.
- flush_i has priority over all events in every state:
  - Next cycle state=IDLE, counters cleared, no done_o.
  - Buffer contents are don't-care.
- Lanes are fully independent; no carry or borrow crosses lane boundaries.

Test Plan:
- deg=3, lane0 inputs 0x05, 0xFE, 0x07, other lanes 0 -> min1=2 idx=1, min2=5, sgn=1; lane0 outputs 0xFE, 0x05, 0xFE; done_o pulses on the 3rd output handshake.
- Saturation: deg=2, lane0 inputs 0x80, 0x7F -> both magnitudes 63, sgn=1; outputs 0x3F, 0xC1.
- Tie: deg=4, all lanes 0x03 each beat -> min1=min2=3, idx=0; every output lane 0x03.
- Backpressure: deg=2 with out_ready_i low 5 cycles -> out_valid_o=1 and out_data_o stable throughout; exactly 2 handshakes total; busy_o drops after the 2nd.
- Illegal degree: start_i with deg_i=1, then deg_i=MAX_DEG+1 -> err_o pulses each time; busy_o stays 0; in_ready_o=0.
- Abort: flush_i during ACC after 2 of 4 beats -> IDLE next cycle, no done_o. A new deg=2 check then yields correct outputs. Repeat with rst_ni low mid-EMIT -> all outputs 0 immediately.
